// File: rtl/vram_arbiter_if.sv
// Pixel-writer handshake and single-port video memory bus, as seen by the arbiter.
interface vram_arbiter_if #(parameter int ADDR_W = 19);
   logic              wr_req;
   logic [9:0]        wr_x;
   logic [9:0]        wr_y;
   logic [11:0]       wr_rgb;
   logic              wr_ack;
   logic              wr_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [11:0]       mem_wdata;
   logic [11:0]       mem_rdata;

   modport slave (
      input  wr_req, wr_x, wr_y, wr_rgb, mem_rdata,
      output wr_ack, wr_err, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output wr_req, wr_x, wr_y, wr_rgb, mem_rdata,
      input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Video memory owner: raster scan reads have absolute priority, pixel writes fill the gaps.
// state  | meaning
// W_IDLE | waiting for wr_req in a write slot
// W_ACK  | ack issued this cycle, wr_req ignored
module vram_arbiter #(
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 px_en,
   vram_arbiter_if.slave        bus,
   output logic [9:0]           h_cnt,
   output logic [9:0]           v_cnt,
   output logic                 frame_start,
   output logic                 de_out,
   output logic [11:0]          rgb_out
);
   localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HA      = 10'(H_ACTIVE);
   localparam logic [9:0] VA      = 10'(V_ACTIVE);

   typedef enum logic {W_IDLE, W_ACK} w_state_t;

   w_state_t          r_state;
   logic [9:0]        r_h;
   logic [9:0]        r_v;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_p1_v;
   logic              r_p1_de;
   logic              r_p2_v;
   logic              r_p2_de;

   logic              w_active;
   logic              w_rd_slot;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_wr_addr;

   assign w_active   = (r_h < HA) && (r_v < VA);
   assign w_rd_slot  = px_en && w_active;
   assign w_in_range = (bus.wr_x < HA) && (bus.wr_y < VA);
   // Constant multiplier; reduces to shifts and adds.
   assign w_wr_addr  = ADDR_W'(bus.wr_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(bus.wr_x);

   assign h_cnt = r_h;
   assign v_cnt = r_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= W_IDLE;
         r_h           <= '0;
         r_v           <= '0;
         r_rd_addr     <= '0;
         r_p1_v        <= 1'b0;
         r_p1_de       <= 1'b0;
         r_p2_v        <= 1'b0;
         r_p2_de       <= 1'b0;
         frame_start   <= 1'b0;
         de_out        <= 1'b0;
         rgb_out       <= '0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
         bus.wr_ack    <= 1'b0;
         bus.wr_err    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         bus.mem_we  <= 1'b0;
         bus.wr_ack  <= 1'b0;
         bus.wr_err  <= 1'b0;

         // Fixed 3-clk pixel pipeline: address, memory read, output register.
         r_p1_v  <= px_en;
         r_p1_de <= w_rd_slot;
         r_p2_v  <= r_p1_v;
         r_p2_de <= r_p1_de;
         if (r_p2_v) begin
            de_out  <= r_p2_de;
            rgb_out <= r_p2_de ? bus.mem_rdata : 12'h000;
         end

         if (px_en) begin
            if (r_h == HT_LAST) begin
               r_h <= '0;
               if (r_v == VT_LAST) begin
                  r_v         <= '0;
                  r_rd_addr   <= '0;
                  frame_start <= 1'b1;
               end else begin
                  r_v <= r_v + 10'd1;
               end
            end else begin
               r_h <= r_h + 10'd1;
            end
         end

         if (w_rd_slot) begin
            bus.mem_addr <= r_rd_addr;
            r_rd_addr    <= r_rd_addr + 1'b1;
         end

         case (r_state)
            W_IDLE: begin
               if (bus.wr_req && !w_rd_slot) begin
                  bus.wr_ack <= 1'b1;
                  r_state    <= W_ACK;
                  if (w_in_range) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= w_wr_addr;
                     bus.mem_wdata <= bus.wr_rgb;
                  end else begin
                     bus.wr_err <= 1'b1;
                  end
               end
            end
            W_ACK:   r_state <= W_IDLE;
            default: r_state <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter on a reduced 48x14 raster (40x10 visible).
module tb_vram_arbiter;
   localparam int HT = 48;
   localparam int VT = 14;
   localparam int HA = 40;
   localparam int VA = 10;
   localparam int AW = 19;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        reset;
   logic        px_en;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        frame_start;
   logic        de_out;
   logic [11:0] rgb_out;

   logic        pre_we;
   logic [9:0]  pre_addr;
   logic [11:0] pre_data;
   logic [11:0] mem [1024];

   int n_vec = 0;
   int n_bad = 0;

   vram_arbiter_if #(.ADDR_W(AW)) bus ();

   vram_arbiter #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset(reset), .px_en(px_en), .bus(bus),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_start(frame_start),
      .de_out(de_out), .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, one clk read latency.
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (bus.mem_we)
         mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[9:0]];
   end

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
      logic        err;
      logic [31:0] addr;
   } wvec_t;

   function automatic logic [11:0] exp_pix(input int a);
      if (a == 0) return 12'hF00;
      if (a == 1) return 12'h0F0;
      return 12'(a * 37 + 5);
   endfunction

   function automatic bit is_act(input int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic int pix_idx(input int p);
      return (p / HT) * HA + (p % HT);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_h_cnt"},       32'(h_cnt), 0);
      chk({tag, "_v_cnt"},       32'(v_cnt), 0);
      chk({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
      chk({tag, "_mem_we"},      32'(bus.mem_we), 0);
      chk({tag, "_mem_wdata"},   32'(bus.mem_wdata), 0);
      chk({tag, "_wr_ack"},      32'(bus.wr_ack), 0);
      chk({tag, "_wr_err"},      32'(bus.wr_err), 0);
      chk({tag, "_frame_start"}, 32'(frame_start), 0);
      chk({tag, "_de_out"},      32'(de_out), 0);
      chk({tag, "_rgb_out"},     32'(rgb_out), 0);
   endtask

   task automatic wait_hv(input int h, input int v, input string nm);
      int n = 0;
      while (!(h_cnt == 10'(h) && v_cnt == 10'(v)) && n < 4 * FR) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 4 * FR), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wvec_t tbl [9];
      int    p;
      int    n;
      int    nack;
      int    last_ack;
      bit    prv_rd;
      int    prv_idx;
      logic [9:0]  cx;
      logic [9:0]  cy;
      logic [11:0] crgb;

      tbl[0] = '{10'd40,   10'd0,    12'h111, 1'b1, 0};
      tbl[1] = '{10'd0,    10'd10,   12'h222, 1'b1, 0};
      tbl[2] = '{10'd39,   10'd9,    12'hFFF, 1'b0, 399};
      tbl[3] = '{10'd0,    10'd0,    12'h123, 1'b0, 0};
      tbl[4] = '{10'd1023, 10'd1023, 12'h333, 1'b1, 0};
      tbl[5] = '{10'd7,    10'd3,    12'h456, 1'b0, 127};
      tbl[6] = '{10'd40,   10'd10,   12'h444, 1'b1, 0};
      tbl[7] = '{10'd39,   10'd0,    12'h0AA, 1'b0, 39};
      tbl[8] = '{10'd0,    10'd9,    12'h5C3, 1'b0, 360};

      reset = 1'b1; px_en = 1'b0;
      bus.wr_req = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
      pre_we = 1'b1;
      for (int a = 0; a < 1024; a++) begin
         pre_addr = 10'(a);
         pre_data = exp_pix(a);
         @(negedge clk);
      end
      pre_we = 1'b0;
      @(negedge clk);
      chk_zero("reset");

      // Counters, frame pulse and read pipeline over two frames with px_en tied high.
      reset = 1'b0; px_en = 1'b1;
      for (int k = 1; k <= 2 * FR + 4; k++) begin
         @(negedge clk);
         chk("h_cnt", 32'(h_cnt), 32'(k % HT));
         chk("v_cnt", 32'(v_cnt), 32'((k / HT) % VT));
         chk("frame_start", 32'(frame_start), 32'(k % FR == 0));
         chk("mem_we_scan", 32'(bus.mem_we), 0);
         p = (k - 1) % FR;
         if (is_act(p)) chk("rd_mem_addr", 32'(bus.mem_addr), 32'(pix_idx(p)));
         if (k >= 3) begin
            p = (k - 3) % FR;
            chk("de_out", 32'(de_out), 32'(is_act(p)));
            chk("rgb_out", 32'(rgb_out), is_act(p) ? 32'(exp_pix(pix_idx(p))) : 0);
         end else begin
            chk("de_out_early", 32'(de_out), 0);
            chk("rgb_out_early", 32'(rgb_out), 0);
         end
      end

      // Write deferred by active video until the first blanking slot.
      wait_hv(10, 0, "wait_h10");
      bus.wr_x = 10'd5; bus.wr_y = 10'd2; bus.wr_rgb = 12'hABC; bus.wr_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.wr_ack && n < 200);
      chk("arb_ack_seen", 32'(bus.wr_ack), 1);
      chk("arb_ack_h", 32'(h_cnt), 32'(HA + 1));
      chk("arb_ack_v", 32'(v_cnt), 0);
      chk("arb_we", 32'(bus.mem_we), 1);
      chk("arb_addr", 32'(bus.mem_addr), 85);
      chk("arb_wdata", 32'(bus.mem_wdata), 32'h0ABC);
      chk("arb_err", 32'(bus.wr_err), 0);
      bus.wr_req = 1'b0;
      @(negedge clk);
      chk("arb_ack_pulse", 32'(bus.wr_ack), 0);
      wait_hv(5, 2, "wait_h5v2");
      repeat (3) @(negedge clk);
      chk("readback_rgb", 32'(rgb_out), 32'h0ABC);
      chk("readback_de", 32'(de_out), 1);

      // Range table, every cycle a write slot.
      px_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         bus.wr_x = tbl[i].x; bus.wr_y = tbl[i].y; bus.wr_rgb = tbl[i].rgb;
         bus.wr_req = 1'b1;
         @(negedge clk);
         chk($sformatf("tbl%0d_ack", i), 32'(bus.wr_ack), 1);
         chk($sformatf("tbl%0d_err", i), 32'(bus.wr_err), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_we", i), 32'(bus.mem_we), 32'(!tbl[i].err));
         if (!tbl[i].err) begin
            chk($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), tbl[i].addr);
            chk($sformatf("tbl%0d_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].rgb));
         end
         bus.wr_req = 1'b0;
         @(negedge clk);
         chk($sformatf("tbl%0d_ack_off", i), 32'(bus.wr_ack), 0);
         chk($sformatf("tbl%0d_err_off", i), 32'(bus.wr_err), 0);
      end

      // Held request: one write every second clk.
      bus.wr_x = 10'd2; bus.wr_y = 10'd1; bus.wr_rgb = 12'h321; bus.wr_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("held_ack%0d", j), 32'(bus.wr_ack), 32'(j % 2 == 0));
      end
      bus.wr_req = 1'b0;
      repeat (2) @(negedge clk);

      // Slot sharing: px_en every 4th clk, request always pending.
      nack = 0; last_ack = -10; prv_rd = 1'b0; prv_idx = 0;
      cx = 10'd0; cy = 10'd0; crgb = 12'h100;
      bus.wr_x = cx; bus.wr_y = cy; bus.wr_rgb = crgb; bus.wr_req = 1'b1;
      for (int i = 0; i < 400; i++) begin
         px_en = (i % 4 == 0);
         prv_rd = px_en && (h_cnt < 10'(HA)) && (v_cnt < 10'(VA));
         prv_idx = int'(v_cnt) * HA + int'(h_cnt);
         @(negedge clk);
         if (prv_rd) begin
            chk("share_rd_addr", 32'(bus.mem_addr), 32'(prv_idx));
            chk("share_rd_we", 32'(bus.mem_we), 0);
         end
         if (bus.mem_we) begin
            chk("share_we_addr", 32'(bus.mem_addr), 32'(int'(cy) * HA + int'(cx)));
            chk("share_we_data", 32'(bus.mem_wdata), 32'(crgb));
         end
         if (bus.wr_ack) begin
            chk("share_ack_gap", 32'(i - last_ack >= 2), 1);
            last_ack = i;
            nack++;
            cx = 10'((nack * 3) % HA); cy = 10'(nack % VA); crgb = 12'(12'h100 + nack);
            bus.wr_x = cx; bus.wr_y = cy; bus.wr_rgb = crgb;
         end
      end
      chk("share_ack_count", 32'(nack >= 100), 1);
      bus.wr_req = 1'b0; px_en = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-line, landing on the cycle a write would be granted.
      px_en = 1'b1;
      wait_hv(30, 3, "wait_h30");
      px_en = 1'b0;
      bus.wr_x = 10'd1; bus.wr_y = 10'd1; bus.wr_rgb = 12'h777; bus.wr_req = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ack", 32'(bus.wr_ack), 1);
      chk("post_rst_we", 32'(bus.mem_we), 1);
      chk("post_rst_addr", 32'(bus.mem_addr), 41);
      chk("post_rst_wdata", 32'(bus.mem_wdata), 32'h0777);
      bus.wr_req = 1'b0; px_en = 1'b1;
      @(negedge clk);
      chk("post_rst_h", 32'(h_cnt), 1);
      chk("post_rst_v", 32'(v_cnt), 0);
      chk("post_rst_fs", 32'(frame_start), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
